// File: rtl/fir_stream_feeder.sv
// FIR input feeder: FIFO-buffered samples, 1-cycle registered output, zero flush, drain wait, done pulse.
// Zero-flush phase is compiled in with `define FIR_FEEDER_ZERO_FLUSH_EN; hold=1 freezes everything but FIFO writes.
module fir_stream_feeder #(
  parameter int dw        = 18,
  parameter int DEPTH     = 16,
  parameter int FLUSH_LEN = 17,
  parameter int DRAIN_LEN = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  input  logic [dw-1:0] s_data,
  input  logic          s_last,
  output logic          s_ready,
  input  logic          hold,
  output logic          clk_ena,
  output logic          i_valid,
  output logic [dw-1:0] i_in,
  output logic          busy,
  output logic          done
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CMAX = (FLUSH_LEN > DRAIN_LEN) ? FLUSH_LEN : DRAIN_LEN;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;

  logic [dw:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty, push, pop;
  logic [dw:0]   head;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          launch, done_nxt, vld_nxt;
  logic [dw-1:0] dat_nxt;

  assign launch  = ~hold;
  assign clk_ena = ~hold;
  assign busy    = (state != IDLE);

  // FIFO entry is {last, data}
  assign s_ready    = (count != (AW+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = s_valid & s_ready;
  assign head       = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {s_last, s_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    if (launch) begin
      case (state)
        IDLE: if (!fifo_empty) state_nxt = STREAM;
        STREAM: if (!fifo_empty && head[dw]) begin
`ifdef FIR_FEEDER_ZERO_FLUSH_EN
          state_nxt = FLUSH;
          cnt_nxt   = CW'(FLUSH_LEN);
`else
          state_nxt = DRAIN;
          cnt_nxt   = CW'(DRAIN_LEN);
`endif
        end
`ifdef FIR_FEEDER_ZERO_FLUSH_EN
        FLUSH: begin
          cnt_nxt = cnt - CW'(1);
          if (cnt <= CW'(1)) begin
            state_nxt = DRAIN;
            cnt_nxt   = CW'(DRAIN_LEN);
          end
        end
`endif
        DRAIN: begin
          cnt_nxt = cnt - CW'(1);
          if (cnt <= CW'(1)) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            done_nxt  = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Values the output register takes on a launch cycle; underrun and drain present zero
  always_comb begin
    pop     = 1'b0;
    vld_nxt = 1'b0;
    dat_nxt = '0;
    case (state)
      STREAM: if (!fifo_empty) begin
        pop     = launch;
        vld_nxt = 1'b1;
        dat_nxt = head[dw-1:0];
      end
`ifdef FIR_FEEDER_ZERO_FLUSH_EN
      FLUSH: vld_nxt = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i_valid <= 1'b0;
      i_in    <= '0;
      done    <= 1'b0;
    end else begin
      done <= done_nxt;
      if (launch) begin
        i_valid <= vld_nxt;
        i_in    <= dat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fir_stream_feeder.sv
// Directed bench for fir_stream_feeder: frame shape, FIFO full, hold toggling, underrun bubbles, mid-frame reset.
module tb_fir_stream_feeder;
  localparam int DW = 18;
  localparam int DL = 24;
`ifdef FIR_FEEDER_ZERO_FLUSH_EN
  localparam int NF = 17;
`else
  localparam int NF = 0;
`endif

  logic          clk = 1'b0;
  logic          reset, s_valid, s_last, hold;
  logic          s_ready, clk_ena, i_valid, busy, done;
  logic [DW-1:0] s_data, i_in;

  int n_chk = 0;
  int n_bad = 0;
  bit log_en = 1'b0;
  bit lh[$], lv[$], ldn[$], lb[$], lce[$];
  int ld[$];
  int ev[$], ed[$], edn[$];

  always #5 clk = ~clk;

  fir_stream_feeder dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .s_ready (s_ready),
    .hold    (hold),
    .clk_ena (clk_ena),
    .i_valid (i_valid),
    .i_in    (i_in),
    .busy    (busy),
    .done    (done)
  );

  // One log entry per edge: the hold applied at that edge and the outputs it produced
  always @(posedge clk) begin
    #1;
    if (log_en) begin
      lh.push_back(hold);
      lv.push_back(i_valid);
      ld.push_back(int'($signed(i_in)));
      ldn.push_back(done);
      lb.push_back(busy);
      lce.push_back(clk_ena);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    lh.delete(); lv.delete(); ld.delete(); ldn.delete(); lb.delete(); lce.delete();
    ev.delete(); ed.delete(); edn.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; hold = 1'b0;
    idle(2);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the transfer edge
  task automatic send(input int d, input bit l);
    int t;
    t = 0;
    s_valid = 1'b1; s_data = DW'(d); s_last = l;
    while (!s_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("send_timeout", int'(s_ready), 1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
  endtask

  task automatic wait_done(input int lim);
    int t;
    t = 0;
    while (!done && t < lim) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("done_seen", int'(done), 1);
  endtask

  // After the frame's samples: NF valid zeros, DL invalid cycles with done on the last, then quiet
  task automatic add_tail();
    for (int i = 0; i < NF; i++) begin ev.push_back(1); ed.push_back(0); edn.push_back(0); end
    for (int i = 0; i < DL; i++) begin ev.push_back(0); ed.push_back(0); edn.push_back(int'(i == DL - 1)); end
    ev.push_back(0); ed.push_back(0); edn.push_back(0);
  endtask

  // Walk the log from the first launched valid sample; held edges must repeat the last launched output
  task automatic compare_log(input string tag);
    int first, j;
    first = -1;
    j = -1;
    for (int n = 0; n < lv.size(); n++)
      if (!lh[n] && lv[n] && first < 0) first = n;
    chk({tag, "_start"}, int'(first >= 0), 1);
    if (first < 0) return;
    for (int n = first; n < lv.size(); n++) begin
      if (!lh[n]) j++;
      if (j >= ev.size()) break;
      chk($sformatf("%s_v[%0d]", tag, j), int'(lv[n]), ev[j]);
      chk($sformatf("%s_d[%0d]", tag, j), ld[n], ed[j]);
      chk($sformatf("%s_done[%0d]", tag, j), int'(ldn[n]), lh[n] ? 0 : edn[j]);
      chk($sformatf("%s_clk_ena[%0d]", tag, j), int'(lce[n]), int'(!lh[n]));
      if (!lh[n] && edn[j] == 1) begin
        chk({tag, "_busy_at_done"}, int'(lb[n]), 0);
        chk({tag, "_busy_before_done"}, int'(lb[n-1]), 1);
      end
    end
    chk({tag, "_len"}, j, ev.size());
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t, nv, nd, nb;
    reset = 1'b1; hold = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;

    // reset state; clk_ena tracks ~hold even in reset
    @(negedge clk);
    chk("rst_clk_ena_h1", int'(clk_ena), 0);
    hold = 1'b0;
    #1 chk("rst_clk_ena_h0", int'(clk_ena), 1);
    @(negedge clk);
    chk("rst_i_valid", int'(i_valid), 0);
    chk("rst_i_in", int'(i_in), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", int'(s_ready), 1);

    // three-sample frame
    clear_log(); log_en = 1'b1;
    send(5, 0); send(-7, 0); send(100, 1);
    wait_done(300); idle(3); log_en = 1'b0;
    ev = '{1, 1, 1}; ed = '{5, -7, 100}; edn = '{0, 0, 0};
    add_tail(); compare_log("frame3");

    // single-sample frame
    do_reset(); clear_log(); log_en = 1'b1;
    send(42, 1);
    wait_done(300); idle(3); log_en = 1'b0;
    ev = '{1}; ed = '{42}; edn = '{0};
    add_tail(); compare_log("single");

    // fill FIFO under hold, refused 17th offer, then drain in order
    do_reset(); clear_log(); hold = 1'b1; log_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("full_rdy_before16", int'(s_ready), 1);
      send(i * 1000 - 7000, i == 15);
      ev.push_back(1); ed.push_back(i * 1000 - 7000); edn.push_back(0);
    end
    chk("full_rdy_after16", int'(s_ready), 0);
    chk("full_clk_ena", int'(clk_ena), 0);
    chk("full_busy_held", int'(busy), 0);
    s_valid = 1'b1; s_data = DW'(777);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("full_rdy_offer17_%0d", i), int'(s_ready), 0);
    end
    s_valid = 1'b0; s_data = '0;
    hold = 1'b0;
    wait_done(300); idle(4); log_en = 1'b0;
    add_tail(); compare_log("full");
    chk("full_idle_after", int'(busy), 0);

    // hold toggling every other cycle
    do_reset(); clear_log(); hold = 1'b1;
    send(11, 0); send(-22, 0); send(33, 0); send(-44, 0); send(55, 0); send(-66, 1);
    log_en = 1'b1;
    for (int c = 0; c < 130; c++) begin
      hold = (c % 2 == 1);
      @(negedge clk);
    end
    hold = 1'b0; idle(3); log_en = 1'b0;
    ev = '{1, 1, 1, 1, 1, 1}; ed = '{11, -22, 33, -44, 55, -66}; edn = '{0, 0, 0, 0, 0, 0};
    add_tail(); compare_log("toggle");

    // upstream pause of three cycles mid-frame
    do_reset(); clear_log(); log_en = 1'b1;
    send(10, 0); idle(1); send(20, 0); send(30, 0); idle(3); send(40, 1);
    wait_done(300); idle(3); log_en = 1'b0;
    ev = '{1, 1, 1, 0, 0, 0, 1}; ed = '{10, 20, 30, 0, 0, 0, 40}; edn = '{0, 0, 0, 0, 0, 0, 0};
    add_tail(); compare_log("pause");

    // reset four cycles after the last sample, with a next-frame sample queued
    do_reset();
    send(1, 0); send(2, 1);
    t = 0;
    while (!(i_valid && $signed(i_in) == 2) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("rstf_last_seen", int'($signed(i_in)), 2);
    s_valid = 1'b1; s_data = DW'(55);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s_valid = 1'b0; s_data = '0;
      chk($sformatf("rstf_tail_v%0d", i), int'(i_valid), int'(NF > 0));
      chk($sformatf("rstf_tail_d%0d", i), int'(i_in), 0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("rstf_i_valid", int'(i_valid), 0);
    chk("rstf_busy", int'(busy), 0);
    chk("rstf_s_ready", int'(s_ready), 1);
    chk("rstf_done", int'(done), 0);
    reset = 1'b0;
    nv = 0; nd = 0; nb = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      nv += int'(i_valid);
      nd += int'(done);
      nb += int'(busy);
    end
    chk("rstf_no_valid", nv, 0);
    chk("rstf_no_done", nd, 0);
    chk("rstf_no_busy", nb, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/fir_stream_feeder.md
FIR_STREAM_FEEDER -- requirements
Module: fir_stream_feeder

Interface
REQ-001 Parameter dw, default 18: sample width in bits, two's complement.
REQ-002 Parameter DEPTH, default 16: input FIFO depth in entries, power of two, at least 4.
REQ-003 Parameter FLUSH_LEN, default 17: number of zero samples sent after a frame's last sample (filter taps minus 1).
REQ-004 Parameter DRAIN_LEN, default 24: number of enabled cycles to wait for the filter's valid pipeline to empty.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 s_valid  in  1  upstream sample valid.
REQ-008 s_data  in  dw  upstream sample.
REQ-009 s_last  in  1  marks the final sample of a frame; qualified by s_valid.
REQ-010 s_ready  out  1  high when the FIFO can accept a sample (not full).
REQ-011 hold  in  1  downstream stall request.
REQ-012 clk_ena  out  1  filter clock enable; combinational, equal to ~hold.
REQ-013 i_valid  out  1  registered sample-valid to the filter.
REQ-014 i_in  out  dw  registered sample to the filter.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 done  out  1  one-cycle pulse when DRAIN completes.

Function
REQ-017 An upstream transfer SHALL occur on a cycle where s_valid and s_ready are both 1; {s_last, s_data} is written to the FIFO.
REQ-018 The FIFO SHALL be first-in first-out, keep an occupancy count of 0..DEPTH, wrap pointers modulo DEPTH, and hold s_ready=0 while occupancy equals DEPTH.
REQ-019 A write and a read in the same cycle SHALL leave occupancy unchanged; this applies at full and at empty.
REQ-020 The state machine SHALL have four states: IDLE, STREAM, FLUSH, DRAIN.
REQ-021 IDLE SHALL move to STREAM on the first cycle the FIFO is non-empty.
REQ-022 Launch cycle: a cycle with hold=0 (the cycle asserts clk_ena). Nothing SHALL advance when hold=1: no FIFO pop, no state or counter change; i_valid and i_in keep their values.
REQ-023 In STREAM, on a launch cycle with the FIFO non-empty, the feeder SHALL pop one entry and register i_in=data, i_valid=1 on the next edge.
REQ-024 In STREAM, on a launch cycle with the FIFO empty, the feeder SHALL register i_valid=0 and i_in=0; an underrun bubble is legal.
REQ-025 Popping an entry with last=1 SHALL move the state to FLUSH, or to DRAIN when flush is compiled out.
REQ-026 Output latency SHALL be 1 cycle: a sample popped at edge k is presented on i_in after edge k.
REQ-027 In FLUSH, each launch cycle SHALL emit i_valid=1, i_in=0; after exactly FLUSH_LEN such cycles the state SHALL move to DRAIN.
REQ-028 In DRAIN, each launch cycle SHALL emit i_valid=0 and decrement a counter loaded with DRAIN_LEN.
REQ-029 When the DRAIN counter reaches 0, the feeder SHALL pulse done=1 for one cycle and return to IDLE.
REQ-030 The FIFO SHALL keep accepting writes during FLUSH and DRAIN; those samples form the next frame, which starts from IDLE.
REQ-031 Simultaneous hold=1 and s_valid=1 with the FIFO not full SHALL still accept the write.

Reset
REQ-032 While reset=1 at a clock edge, the block SHALL force: state=IDLE; FIFO pointers and occupancy=0; counters=0; i_valid=0; i_in=0; done=0; busy=0.
REQ-033 s_ready SHALL read 1 in the cycle after reset.
REQ-034 Reset asserted mid-frame SHALL discard all FIFO contents and abort FLUSH or DRAIN; no done pulse SHALL be produced.
REQ-035 clk_ena SHALL follow ~hold even during reset.

Configuration
REQ-036 Macro FIR_FEEDER_ZERO_FLUSH_EN defined: the FLUSH state and its counter SHALL exist, behaving as REQ-027.
REQ-037 Macro not defined: FLUSH logic SHALL be absent, and a last-sample pop SHALL go directly to DRAIN; all other behaviour is identical.

Verification
REQ-038 Reset then write 3 samples 5, -7, 100 (last on 100) with hold=0 and the macro defined -> i_in carries 5, -7, 100 with i_valid=1, then 17 zeros with i_valid=1, then 24 cycles of i_valid=0, then done pulses once and busy falls.
REQ-039 Write 16 samples with no reads (hold=1) -> s_ready=0 after the 16th write; the 17th offer is not accepted; after hold=0, the 16 values come out in order.
REQ-040 Toggle hold every other cycle during STREAM -> each sample appears exactly once; i_in is stable while hold=1; clk_ena equals ~hold every cycle.
REQ-041 Assert reset during FLUSH (after 4 zeros) -> the next cycle shows i_valid=0, busy=0, s_ready=1, and no done pulse.
REQ-042 Macro undefined, single sample 42 with last -> i_in=42, i_valid=1 for one cycle, then 24 cycles of i_valid=0, then done.
REQ-043 Upstream pauses 3 cycles mid-frame -> 3 bubble cycles with i_valid=0, i_in=0; the frame then resumes in order.
